// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-input CBus arbiter in front of the single external
// oreq/oresp port. It selects a requester by round-robin or fixed priority,
// holds the registered grant for the whole burst and returns to IDLE after
// the beat that carries ready && last.
// Optional feature macro: CBUS_ARB_TRANS_EN. When it is defined, the
// kseg0/kseg1 virtual addresses on oreq.addr are translated to physical
// addresses inside this block.

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0] iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp,
  output logic                        busy
);

  localparam int SEL_W = $clog2(NUM_INPUTS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]            state_reg, state_next;
  logic [SEL_W-1:0]      sel_reg, sel_next;
  logic [SEL_W-1:0]      last_sel_reg, last_sel_next;
  logic [SEL_W-1:0]      winner;
  logic [NUM_INPUTS-1:0] valid_vec;
  logic                  any_valid;
  cbus_req_t             granted_req;

  // The kseg0 and kseg1 windows (0x8000_0000-0xBFFF_FFFF) both map onto the
  // low 512 MiB of physical memory. Every other segment is passed through.
  function automatic logic [31:0] xlate_addr(input logic [31:0] vaddr);
`ifdef CBUS_ARB_TRANS_EN
    if (vaddr[31:30] == 2'b10) begin
      return {3'b000, vaddr[28:0]};
    end
    return vaddr;
`else
    return vaddr;
`endif
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_valid
      assign valid_vec[gi] = ireqs[gi].valid;
    end
  endgenerate

  assign any_valid = |valid_vec;

  // Pick the winner among the valid requesters. The loops scan from the
  // lowest-priority candidate to the highest, so the last hit is the one
  // that wins.
  always_comb begin
    winner = '0;
    if (ROUND_ROBIN) begin
      // Candidate order is last_sel+1, last_sel+2, ... wrapping, and ends
      // with last_sel itself (k == NUM_INPUTS).
      for (int k = NUM_INPUTS; k >= 1; k--) begin
        logic [SEL_W:0] cand;
        cand = {1'b0, last_sel_reg} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(NUM_INPUTS)) begin
          cand = cand - (SEL_W+1)'(NUM_INPUTS);
        end
        if (valid_vec[cand[SEL_W-1:0]]) begin
          winner = cand[SEL_W-1:0];
        end
      end
    end else begin
      // Fixed priority: index 0 is the highest priority.
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (valid_vec[i]) begin
          winner = SEL_W'(i);
        end
      end
    end
  end

  // Next-state logic. A grant is taken only from IDLE and is released only
  // by ready && last, so late arrivals never preempt a burst.
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    last_sel_next = last_sel_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          sel_next   = winner;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (oresp.ready && oresp.last) begin
          last_sel_next = sel_reg;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers. Reset wins over everything, including a burst in flight,
  // and points last_sel at the top index so that index 0 is scanned first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      last_sel_reg <= SEL_W'(NUM_INPUTS - 1);
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      last_sel_reg <= last_sel_next;
    end
  end

  // Forward the granted request. A requester that drops valid mid-burst is
  // still forwarded as-is, so the external bus sees valid fall.
  always_comb begin
    granted_req      = ireqs[sel_reg];
    granted_req.addr = xlate_addr(ireqs[sel_reg].addr);
    oreq             = '0;
    if (state_reg == BUSY) begin
      oreq = granted_req;
    end
  end

  // Responses are routed combinationally to the granted requester only.
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_resp
      assign iresps[gi] = ((state_reg == BUSY) && (sel_reg == SEL_W'(gi))) ? oresp : '0;
    end
  endgenerate

  assign busy = (state_reg == BUSY);

endmodule
